// File: rtl/mux4to1_pkg.sv
// Shared definitions for the 4:1 lane multiplexer.
//   MUX4_SEL_W : width of the lane select
//   MUX4_MAX_W : widest lane mux4_pick can handle
//   mux4_sel_e : lane select codes
//   mux4_pick  : width-generic lane pick (lane i = d[i*width +: width])
package mux4to1_pkg;

  localparam int unsigned MUX4_SEL_W = 2;
  localparam int unsigned MUX4_MAX_W = 64;

  typedef enum logic [MUX4_SEL_W-1:0] {
    SEL_L0 = 2'd0,
    SEL_L1 = 2'd1,
    SEL_L2 = 2'd2,
    SEL_L3 = 2'd3
  } mux4_sel_e;

  function automatic logic [MUX4_MAX_W-1:0] mux4_pick(
    input logic [4*MUX4_MAX_W-1:0] d,
    input logic [MUX4_SEL_W-1:0]   sel,
    input int unsigned             width
  );
    logic [4*MUX4_MAX_W-1:0] shifted;
    logic [MUX4_MAX_W-1:0]   r;
    shifted = d >> (32'(sel) * width);
    r = '0;
    for (int unsigned i = 0; i < MUX4_MAX_W; i++) begin
      if (i < width) r[i] = shifted[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/mux4to1_if.sv
// Lane-select bus for mux4to1.
//   d         : 4 packed lanes, lane 0 at LSBs
//   sel       : lane select
//   in_valid  : qualifies d/sel
//   y         : selected lane
//   out_valid : y holds a freshly selected value
// master drives d/sel/in_valid; slave (the mux) drives y/out_valid.
interface mux4to1_if #(
  parameter int unsigned WIDTH = 1
);
  import mux4to1_pkg::*;

  logic [4*WIDTH-1:0]    d;
  logic [MUX4_SEL_W-1:0] sel;
  logic                  in_valid;
  logic [WIDTH-1:0]      y;
  logic                  out_valid;

  modport master (output d, sel, in_valid, input y, out_valid);
  modport slave  (input d, sel, in_valid, output y, out_valid);

endinterface

// File: rtl/mux4to1_comb.sv
// Pure combinational 4:1 lane selector.
//   d   : 4 packed WIDTH-bit lanes, lane 0 at LSBs
//   sel : lane select (all four codes legal)
//   y   : selected lane
module mux4to1_comb
  import mux4to1_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [4*WIDTH-1:0]    d,
  input  logic [MUX4_SEL_W-1:0] sel,
  output logic [WIDTH-1:0]      y
);

  always_comb begin
    y = '0;
    case (mux4_sel_e'(sel))
      SEL_L0: y = d[0*WIDTH +: WIDTH];
      SEL_L1: y = d[1*WIDTH +: WIDTH];
      SEL_L2: y = d[2*WIDTH +: WIDTH];
      SEL_L3: y = d[3*WIDTH +: WIDTH];
    endcase
  end

endmodule

// File: rtl/mux4to1.sv
// Registered 4:1 lane multiplexer.
//   clk   : rising-edge clock (unused when REG_OUT=0)
//   rst_n : asynchronous active-low reset (unused when REG_OUT=0)
//   bus   : lane-select bus (d, sel, in_valid in; y, out_valid out)
// REG_OUT=1: y/out_valid updated one cycle after in_valid is sampled;
// y holds its value on idle cycles. REG_OUT=0: fully combinational.
module mux4to1
  import mux4to1_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  mux4to1_if.slave  bus
);

  logic [WIDTH-1:0] pick;

  mux4to1_comb #(.WIDTH(WIDTH)) u_comb (
    .d   (bus.d),
    .sel (bus.sel),
    .y   (pick)
  );

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] y_q;
      logic             valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_q     <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= bus.in_valid;
          if (bus.in_valid) y_q <= pick;
        end
      end

      assign bus.y         = y_q;
      assign bus.out_valid = valid_q;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst_n};

      assign bus.y         = pick;
      assign bus.out_valid = bus.in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_mux4to1.sv
// Bench for mux4to1: registered instances at WIDTH 1/8/4 plus a
// combinational WIDTH=1 instance, all sharing one clock and reset.
module tb_mux4to1;
  import mux4to1_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mux4to1_if #(.WIDTH(1)) bus1 ();
  mux4to1_if #(.WIDTH(8)) bus8 ();
  mux4to1_if #(.WIDTH(4)) bus4 ();
  mux4to1_if #(.WIDTH(1)) busc ();

  mux4to1 #(.WIDTH(1), .REG_OUT(1'b1)) dut_w1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mux4to1 #(.WIDTH(8), .REG_OUT(1'b1)) dut_w8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  mux4to1 #(.WIDTH(4), .REG_OUT(1'b1)) dut_w4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  mux4to1 #(.WIDTH(1), .REG_OUT(1'b0)) dut_c  (.clk(clk), .rst_n(rst_n), .bus(busc));

  task automatic test_reset();
    #2;
    checks++; if (bus1.y !== 1'b0) begin failures++; $display("FAIL reset_w1_y got=%0h exp=0", bus1.y); end
    checks++; if (bus1.out_valid !== 1'b0) begin failures++; $display("FAIL reset_w1_ov got=%0h exp=0", bus1.out_valid); end
    checks++; if (bus8.y !== 8'h00) begin failures++; $display("FAIL reset_w8_y got=%0h exp=0", bus8.y); end
    checks++; if (bus4.out_valid !== 1'b0) begin failures++; $display("FAIL reset_w4_ov got=%0h exp=0", bus4.out_valid); end
    @(negedge clk) rst_n = 1'b1;
    // load y=1 so the asynchronous clear is visible
    @(negedge clk);
    bus1.d = 4'b0010; bus1.sel = 2'd1; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus1.y !== 1'b1) begin failures++; $display("FAIL reset_preload_y got=%0h exp=1", bus1.y); end
    bus1.in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus1.y !== 1'b0) begin failures++; $display("FAIL reset_async_y got=%0h exp=0", bus1.y); end
    checks++; if (bus1.out_valid !== 1'b0) begin failures++; $display("FAIL reset_async_ov got=%0h exp=0", bus1.out_valid); end
    @(posedge clk); #1;
    checks++; if (bus1.y !== 1'b0) begin failures++; $display("FAIL reset_hold_y got=%0h exp=0", bus1.y); end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (bus1.y !== 1'b0) begin failures++; $display("FAIL reset_idle_y[%0d] got=%0h exp=0", i, bus1.y); end
      checks++; if (bus1.out_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_ov[%0d] got=%0h exp=0", i, bus1.out_valid); end
    end
  endtask

  task automatic test_sel_sweep_w1();
    logic [3:0] exp_seq;
    exp_seq = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      bus1.d = 4'b1010; bus1.sel = 2'(s); bus1.in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus1.y !== exp_seq[s]) begin failures++; $display("FAIL sweep_w1_y sel=%0d got=%0h exp=%0h", s, bus1.y, exp_seq[s]); end
      checks++; if (bus1.out_valid !== 1'b1) begin failures++; $display("FAIL sweep_w1_ov sel=%0d got=%0h exp=1", s, bus1.out_valid); end
    end
    @(negedge clk) bus1.in_valid = 1'b0;
  endtask

  task automatic test_wide_w8();
    @(negedge clk);
    bus8.d = {8'hDD, 8'hCC, 8'hBB, 8'hAA}; bus8.sel = 2'd2; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus8.y !== 8'hCC) begin failures++; $display("FAIL wide_sel2 got=%0h exp=cc", bus8.y); end
    @(negedge clk) bus8.sel = 2'd3;
    @(posedge clk); #1;
    checks++; if (bus8.y !== 8'hDD) begin failures++; $display("FAIL wide_sel3 got=%0h exp=dd", bus8.y); end
    checks++; if (bus8.out_valid !== 1'b1) begin failures++; $display("FAIL wide_ov got=%0h exp=1", bus8.out_valid); end
    @(negedge clk) bus8.in_valid = 1'b0;
  endtask

  task automatic test_hold();
    @(negedge clk);
    bus1.d = 4'b1010; bus1.sel = 2'd1; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus1.y !== 1'b1) begin failures++; $display("FAIL hold_load_y got=%0h exp=1", bus1.y); end
    @(negedge clk);
    bus1.d = 4'b0000; bus1.sel = 2'd0; bus1.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (bus1.y !== 1'b1) begin failures++; $display("FAIL hold_y[%0d] got=%0h exp=1", i, bus1.y); end
      checks++; if (bus1.out_valid !== 1'b0) begin failures++; $display("FAIL hold_ov[%0d] got=%0h exp=0", i, bus1.out_valid); end
    end
  endtask

  task automatic test_comb();
    logic [3:0] exp_seq;
    logic       iv;
    exp_seq = 4'b0110;
    busc.d = 4'b0110;
    for (int s = 0; s < 4; s++) begin
      iv = 1'($urandom_range(0, 1));
      busc.sel = 2'(s); busc.in_valid = iv;
      #1;
      checks++; if (busc.y !== exp_seq[s]) begin failures++; $display("FAIL comb_y sel=%0d got=%0h exp=%0h", s, busc.y, exp_seq[s]); end
      checks++; if (busc.out_valid !== iv) begin failures++; $display("FAIL comb_ov sel=%0d got=%0h exp=%0h", s, busc.out_valid, iv); end
      busc.in_valid = ~iv;
      #1;
      checks++; if (busc.out_valid !== ~iv) begin failures++; $display("FAIL comb_ov_toggle sel=%0d got=%0h exp=%0h", s, busc.out_valid, ~iv); end
    end
  endtask

  task automatic test_random_w4();
    logic [3:0]            exp_y;
    logic                  exp_ov;
    logic [MUX4_MAX_W-1:0] picked;
    int                    errs;
    exp_y = 4'h0;  // instance has only ever been reset so far
    errs  = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      bus4.d        = 16'($urandom);
      bus4.sel      = 2'($urandom_range(0, 3));
      bus4.in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      exp_ov = bus4.in_valid;
      if (bus4.in_valid) begin
        picked = mux4_pick(256'(bus4.d), bus4.sel, 4);
        exp_y  = picked[3:0];
      end
      checks++;
      if (bus4.y !== exp_y || bus4.out_valid !== exp_ov) begin
        failures++;
        if (errs < 10) $display("FAIL rand_w4 cycle=%0d y=%0h exp_y=%0h ov=%0h exp_ov=%0h", n, bus4.y, exp_y, bus4.out_valid, exp_ov);
        errs++;
      end
    end
    @(negedge clk) bus4.in_valid = 1'b0;
  endtask

  initial begin
    bus1.d = '0; bus1.sel = '0; bus1.in_valid = 1'b0;
    bus8.d = '0; bus8.sel = '0; bus8.in_valid = 1'b0;
    bus4.d = '0; bus4.sel = '0; bus4.in_valid = 1'b0;
    busc.d = '0; busc.sel = '0; busc.in_valid = 1'b0;
    test_reset();
    test_sel_sweep_w1();
    test_wide_w8();
    test_hold();
    test_comb();
    test_random_w4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
